oam_dma_ctrl: RTL and testbench

- Sprite DMA engine for the 2A03. It sits directly downstream of the CPU core's memory port (mem_addr_h/mem_addr_l, mem_rw, write data).
- A CPU write to the trigger address starts the transfer. The engine halts the CPU through cpu_rdy and takes the external memory bus through dma_bus_req.
- It copies 256 bytes from page {page,8'h00} to the PPU OAM data port, one read/write pair per byte. It then releases the bus and the CPU.

---
 rtl/oam_dma_ctrl.sv | 115 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// oam_dma_ctrl: 2A03 sprite DMA, copies {page,00..FF} to the OAM data port.
// Define OAM_DMA_PARITY_ALIGN_EN to add get/put cycle alignment (ALIGN).
module oam_dma_ctrl #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] OAM_ADDR  = 16'h2004
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cpu_addr_l,
  input  logic [7:0] cpu_addr_h,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_wdata,
  input  logic [7:0] bus_rdata,
  output logic       cpu_rdy,
  output logic       dma_bus_req,
  output logic [7:0] dma_addr_l,
  output logic [7:0] dma_addr_h,
  output logic       dma_rw,
  output logic [7:0] dma_wdata,
  output logic       dma_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    READ  = 3'd2,
    WRITE = 3'd3,
    ALIGN = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] page;
  logic [7:0] idx;
  logic [7:0] data_buf;
  logic       trig;

`ifdef OAM_DMA_PARITY_ALIGN_EN
  logic parity;
`endif

  assign trig = !cpu_rw &&
                ({cpu_addr_h, cpu_addr_l} == TRIG_ADDR);

  assign dma_wdata = data_buf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      page        <= 8'h00;
      idx         <= 8'h00;
      data_buf    <= 8'h00;
      cpu_rdy     <= 1'b1;
      dma_bus_req <= 1'b0;
      dma_addr_h  <= 8'h00;
      dma_addr_l  <= 8'h00;
      dma_rw      <= 1'b1;
      dma_done    <= 1'b0;
`ifdef OAM_DMA_PARITY_ALIGN_EN
      parity      <= 1'b0;
`endif
    end else begin
`ifdef OAM_DMA_PARITY_ALIGN_EN
      parity   <= ~parity;
`endif
      dma_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig) begin
            page    <= cpu_wdata;
            idx     <= 8'h00;
            cpu_rdy <= 1'b0;
            state   <= HALT;
          end
        end
        HALT: begin
          dma_bus_req <= 1'b1;
          dma_rw      <= 1'b1;
          dma_addr_h  <= page;
          dma_addr_l  <= idx;
`ifdef OAM_DMA_PARITY_ALIGN_EN
          // next cycle is a put cycle: burn it so READ lands on get
          state <= parity ? READ : ALIGN;
`else
          state <= READ;
`endif
        end
        ALIGN: begin
          state <= READ;
        end
        READ: begin
          data_buf                 <= bus_rdata;
          dma_rw                   <= 1'b0;
          {dma_addr_h, dma_addr_l} <= OAM_ADDR;
          state                    <= WRITE;
        end
        WRITE: begin
          idx    <= idx + 8'd1;
          dma_rw <= 1'b1;
          if (idx == 8'hFF) begin
            cpu_rdy     <= 1'b1;
            dma_bus_req <= 1'b0;
            dma_done    <= 1'b1;
            state       <= IDLE;
          end else begin
            dma_addr_h <= page;
            dma_addr_l <= idx + 8'd1;
            state      <= READ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// tb_oam_dma_ctrl: directed bench for the sprite DMA controller.
// Memory model returns addr[7:0]^8'h5A for every location.
module tb_oam_dma_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] cpu_addr_l;
  logic [7:0] cpu_addr_h;
  logic       cpu_rw;
  logic [7:0] cpu_wdata;
  logic [7:0] bus_rdata;
  logic       cpu_rdy;
  logic       dma_bus_req;
  logic [7:0] dma_addr_l;
  logic [7:0] dma_addr_h;
  logic       dma_rw;
  logic [7:0] dma_wdata;
  logic       dma_done;

  oam_dma_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr_l (cpu_addr_l),
    .cpu_addr_h (cpu_addr_h),
    .cpu_rw     (cpu_rw),
    .cpu_wdata  (cpu_wdata),
    .bus_rdata  (bus_rdata),
    .cpu_rdy    (cpu_rdy),
    .dma_bus_req(dma_bus_req),
    .dma_addr_l (dma_addr_l),
    .dma_addr_h (dma_addr_h),
    .dma_rw     (dma_rw),
    .dma_wdata  (dma_wdata),
    .dma_done   (dma_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] dma_addr;
  assign dma_addr  = {dma_addr_h, dma_addr_l};
  assign bus_rdata = dma_addr[7:0] ^ 8'h5A;

  // cycle parity: 0 in the first cycle after a reset edge
  int cyc = 0;
  always @(posedge clk) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic [15:0] rd_addr [0:4095];
  bit          rd_par  [0:4095];
  logic [7:0]  wr_data [0:4095];
  int rd_n = 0;
  int wr_n = 0;
  int stall_n = 0;
  int done_n = 0;
  int bad_wr = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!cpu_rdy) stall_n <= stall_n + 1;
      if (dma_done) done_n <= done_n + 1;
      if (dma_bus_req && dma_rw && rd_n < 4096) begin
        rd_addr[rd_n] <= dma_addr;
        rd_par[rd_n]  <= cyc[0];
        rd_n          <= rd_n + 1;
      end
      if (dma_bus_req && !dma_rw && wr_n < 4096) begin
        if (dma_addr != 16'h2004) bad_wr <= bad_wr + 1;
        wr_data[wr_n] <= dma_wdata;
        wr_n          <= wr_n + 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  int s_rd, s_wr, s_st, s_dn, s_bw;
  bit ok, done_at;

  task automatic cpu_cyc(input logic [15:0] a, input logic rw,
                         input logic [7:0] d);
    @(negedge clk);
    {cpu_addr_h, cpu_addr_l} = a;
    cpu_rw    = rw;
    cpu_wdata = d;
    @(negedge clk);
    {cpu_addr_h, cpu_addr_l} = 16'h0000;
    cpu_rw    = 1'b1;
    cpu_wdata = 8'h00;
  endtask

  // trigger in a cycle of the requested parity, then wait for release
  task automatic run_xfer(input logic [7:0] pg, input bit par);
    s_rd = rd_n; s_wr = wr_n; s_st = stall_n;
    s_dn = done_n; s_bw = bad_wr;
    ok = 1'b0; done_at = 1'b0;
    do @(negedge clk); while (cyc[0] != par);
    {cpu_addr_h, cpu_addr_l} = 16'h4014;
    cpu_rw    = 1'b0;
    cpu_wdata = pg;
    @(negedge clk);
    {cpu_addr_h, cpu_addr_l} = 16'h0000;
    cpu_rw    = 1'b1;
    cpu_wdata = 8'h00;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (cpu_rdy) begin
        ok = 1'b1;
        done_at = dma_done;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    int bad;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if ({cpu_rdy, dma_bus_req, dma_rw, dma_done} !== 4'b1010) begin
        fails++;
        $display("FAIL reset_idle cyc%0d: rdy/req/rw/done=%b want 1010",
                 i, {cpu_rdy, dma_bus_req, dma_rw, dma_done});
      end
    end
    tests++;
    bad = (dma_addr !== 16'h0000 || dma_wdata !== 8'h00) ? 1 : 0;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_vals: addr=%h wdata=%h want 0000 00",
               dma_addr, dma_wdata);
    end
  endtask

  task automatic test_no_trigger;
    int bad = 0;
    cpu_cyc(16'h4014, 1'b1, 8'h03);
    cpu_cyc(16'h4015, 1'b0, 8'h03);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!cpu_rdy || dma_bus_req) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL no_trigger: %0d busy cycles, want 0", bad);
    end
  endtask

  task automatic test_basic;
    int bad = 0;
    run_xfer(8'h03, 1'b0);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL basic_timeout: cpu_rdy never returned");
    end
    tests++;
    if (stall_n - s_st != 513) begin
      fails++;
      $display("FAIL basic_stall: %0d want 513", stall_n - s_st);
    end
    tests++;
    if (done_n - s_dn != 1 || !done_at) begin
      fails++;
      $display("FAIL basic_done: pulses=%0d at_release=%0b want 1 1",
               done_n - s_dn, done_at);
    end
    tests++;
    if (rd_n - s_rd != 256 || wr_n - s_wr != 256) begin
      fails++;
      $display("FAIL basic_count: rd=%0d wr=%0d want 256 256",
               rd_n - s_rd, wr_n - s_wr);
    end
    for (int i = 0; i < 256; i++) begin
      if (rd_addr[s_rd+i] !== 16'h0300 + 16'(i)) bad++;
      if (wr_data[s_wr+i] !== (8'(i) ^ 8'h5A)) bad++;
`ifdef OAM_DMA_PARITY_ALIGN_EN
      if (rd_par[s_rd+i] !== 1'b0) bad++;
`endif
    end
    tests++;
    if (bad != 0 || bad_wr != s_bw) begin
      fails++;
      $display("FAIL basic_data: %0d bad addr/data, %0d bad wr addr",
               bad, bad_wr - s_bw);
    end
  endtask

  task automatic test_align;
    int bad = 0;
    int b;
`ifdef OAM_DMA_PARITY_ALIGN_EN
    int exp_st = 514;
    int exp_rd = 257;
`else
    int exp_st = 513;
    int exp_rd = 256;
`endif
    run_xfer(8'h03, 1'b1);
    b = s_rd + exp_rd - 256;
    tests++;
    if (!ok || stall_n - s_st != exp_st) begin
      fails++;
      $display("FAIL align_stall: ok=%0b stall=%0d want 1 %0d",
               ok, stall_n - s_st, exp_st);
    end
    tests++;
    if (rd_n - s_rd != exp_rd || wr_n - s_wr != 256) begin
      fails++;
      $display("FAIL align_count: rd=%0d wr=%0d want %0d 256",
               rd_n - s_rd, wr_n - s_wr, exp_rd);
    end
    tests++;
    if (rd_addr[s_rd] !== 16'h0300) begin
      fails++;
      $display("FAIL align_first: %h want 0300", rd_addr[s_rd]);
    end
    for (int i = 0; i < 256; i++) begin
      if (rd_addr[b+i] !== 16'h0300 + 16'(i)) bad++;
      if (wr_data[s_wr+i] !== (8'(i) ^ 8'h5A)) bad++;
`ifdef OAM_DMA_PARITY_ALIGN_EN
      if (rd_par[b+i] !== 1'b0) bad++;
`endif
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL align_data: %0d bad entries, want 0", bad);
    end
  endtask

  task automatic test_reset_mid;
    int w = 0;
    bit hit = 1'b0;
    do @(negedge clk); while (cyc[0] != 1'b0);
    {cpu_addr_h, cpu_addr_l} = 16'h4014;
    cpu_rw    = 1'b0;
    cpu_wdata = 8'h07;
    @(negedge clk);
    cpu_rw    = 1'b1;
    {cpu_addr_h, cpu_addr_l} = 16'h0000;
    for (int i = 0; i < 1200; i++) begin
      if (dma_bus_req && !dma_rw) begin
        if (w == 8'h40) begin
          rst_n = 1'b0;
          hit = 1'b1;
          break;
        end
        w++;
      end
      @(negedge clk);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL mid_reach: write idx 40 not seen, got %0d", w);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tests++;
    if ({cpu_rdy, dma_bus_req, dma_rw, dma_done} !== 4'b1010) begin
      fails++;
      $display("FAIL mid_release: rdy/req/rw/done=%b want 1010",
               {cpu_rdy, dma_bus_req, dma_rw, dma_done});
    end
    run_xfer(8'h07, 1'b0);
    tests++;
    if (!ok || rd_n - s_rd != 256 || stall_n - s_st != 513) begin
      fails++;
      $display("FAIL mid_restart: ok=%0b rd=%0d stall=%0d want 1 256 513",
               ok, rd_n - s_rd, stall_n - s_st);
    end
    tests++;
    if (rd_addr[s_rd] !== 16'h0700 || wr_data[s_wr] !== 8'h5A) begin
      fails++;
      $display("FAIL mid_first: addr=%h data=%h want 0700 5a",
               rd_addr[s_rd], wr_data[s_wr]);
    end
  endtask

  task automatic test_reset_trigger;
    int bad = 0;
    @(negedge clk);
    rst_n = 1'b0;
    {cpu_addr_h, cpu_addr_l} = 16'h4014;
    cpu_rw    = 1'b0;
    cpu_wdata = 8'h05;
    @(negedge clk);
    rst_n  = 1'b1;
    cpu_rw = 1'b1;
    {cpu_addr_h, cpu_addr_l} = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!cpu_rdy || dma_bus_req) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL reset_trig: %0d busy cycles, want 0", bad);
    end
  endtask

  task automatic test_page_ff;
    int bad = 0;
    int rd_end;
    run_xfer(8'hFF, 1'b0);
    tests++;
    if (!ok || rd_n - s_rd != 256) begin
      fails++;
      $display("FAIL ff_count: ok=%0b rd=%0d want 1 256",
               ok, rd_n - s_rd);
    end
    tests++;
    if (rd_addr[s_rd+255] !== 16'hFFFF) begin
      fails++;
      $display("FAIL ff_last: %h want ffff", rd_addr[s_rd+255]);
    end
    for (int i = s_rd; i < rd_n; i++)
      if (rd_addr[i][15:8] !== 8'hFF) bad++;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL ff_wrap: %0d reads outside page ff, want 0", bad);
    end
    rd_end = rd_n;
    repeat (6) @(negedge clk);
    tests++;
    if (rd_n != rd_end || !cpu_rdy || dma_bus_req) begin
      fails++;
      $display("FAIL ff_idle: extra=%0d rdy=%0b req=%0b want 0 1 0",
               rd_n - rd_end, cpu_rdy, dma_bus_req);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cpu_addr_l = 8'h00;
    cpu_addr_h = 8'h00;
    cpu_rw     = 1'b1;
    cpu_wdata  = 8'h00;
    test_reset;
    test_no_trigger;
    test_basic;
    test_align;
    test_reset_mid;
    test_reset_trigger;
    test_page_ff;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
